// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked registered ALU with N/Z/V/C flags and iterative shift-add multiply
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic [3:0]       Select,
    output logic [WIDTH-1:0] Output,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             isNegative,
    output logic             isZero,
    output logic             Overflow,
    output logic             CarryOut
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_OR  = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SUB = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     out_q, out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [SHW-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [WIDTH:0]       sum_ext;
    logic [2*WIDTH-1:0]   partial, acc_next;
    logic                 accept;

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath works straight off the input operands at the accept edge.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_ext = '0;
        case (Select)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_SLL: alu_res = A << B[SHW-1:0];
            OP_SRL: alu_res = A >> B[SHW-1:0];
            OP_SUB: begin
                sum_ext = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_MUL: alu_res = '0;
            default: begin
                sum_ext = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
        endcase
    end

    assign partial  = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_next = acc_q + partial;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        n_d         = n_q;
        z_d         = z_q;
        v_d         = v_q;
        c_d         = c_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (Select == OP_MUL) begin
                        state_d     = MUL;
                        out_valid_d = 1'b0;
                        mcand_d     = A;
                        mplier_d    = B;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_d       = alu_res;
                        n_d         = alu_res[WIDTH-1];
                        z_d         = (alu_res == '0);
                        v_d         = alu_v;
                        c_d         = alu_c;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last iteration folds its partial product straight into the result.
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    out_d       = acc_next[WIDTH-1:0];
                    n_d         = acc_next[WIDTH-1];
                    z_d         = (acc_next[WIDTH-1:0] == '0);
                    v_d         = 1'b0;
                    c_d         = |acc_next[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            n_q         <= n_d;
            z_q         <= z_d;
            v_q         <= v_d;
            c_q         <= c_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign Output     = out_q;
    assign out_valid  = out_valid_q;
    assign isNegative = n_q;
    assign isZero     = z_q;
    assign Overflow   = v_q;
    assign CarryOut   = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at WIDTH=32 and WIDTH=8
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        iv32 = 1'b0, ir32, cin32 = 1'b0, ov32, or32 = 1'b1;
    logic [31:0] a32 = '0, b32 = '0, o32;
    logic [3:0]  sel32 = '0;
    logic        n32, z32, v32, c32;

    logic        iv8 = 1'b0, ir8, cin8 = 1'b0, ov8, or8 = 1'b1;
    logic [7:0]  a8 = '0, b8 = '0, o8;
    logic [3:0]  sel8 = '0;
    logic        n8, z8, v8, c8;

    int checks = 0;
    int passed = 0;

    seq_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir32),
        .A(a32), .B(b32), .cin(cin32), .Select(sel32),
        .Output(o32), .out_valid(ov32), .out_ready(or32),
        .isNegative(n32), .isZero(z32), .Overflow(v32), .CarryOut(c32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .cin(cin8), .Select(sel8),
        .Output(o8), .out_valid(ov8), .out_ready(or8),
        .isNegative(n8), .isZero(z8), .Overflow(v8), .CarryOut(c8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue32(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                           input logic c);
        iv32 = 1'b1; sel32 = sel; a32 = a; b32 = b; cin32 = c;
        @(posedge clk); #1;
        iv32 = 1'b0;
    endtask

    task automatic res32(input string tag, input logic [31:0] exp_o, input logic [3:0] exp_nzvc);
        check({tag, " valid"}, 32'(ov32), 32'd1);
        check({tag, " out"}, o32, exp_o);
        check({tag, " nzvc"}, 32'({n32, z32, v32, c32}), 32'(exp_nzvc));
    endtask

    task automatic mul32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_o, input logic [3:0] exp_nzvc);
        int cyc;
        int busy;
        issue32(4'd8, a, b, 1'b0);
        a32 = 32'hDEAD_BEEF; b32 = 32'hFFFF_FFFF; sel32 = 4'd0;
        cyc = 0; busy = 0;
        while (!ov32 && cyc < 100) begin
            if (!ir32) busy++;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd32);
        check({tag, " in_ready low cycles"}, 32'(busy), 32'd32);
        res32(tag, exp_o, exp_nzvc);
    endtask

    initial begin
        int cyc;
        int stale;

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(ov32), 32'd0);
        check("reset Output", o32, 32'd0);
        check("reset nzvc", 32'({n32, z32, v32, c32}), 32'd0);
        check("reset in_ready", 32'(ir32), 32'd1);
        check("reset8 Output/valid", {23'd0, ov8, o8}, 32'd0);
        reset = 1'b0;

        issue32(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        res32("add ovf", 32'h8000_0000, 4'b1010);
        issue32(4'd0, 32'hFFFF_FFFF, 32'd0, 1'b1);
        res32("add carry", 32'h0, 4'b0101);
        issue32(4'd7, 32'd5, 32'd5, 1'b0);
        res32("sub 5-5", 32'h0, 4'b0101);
        issue32(4'd7, 32'd0, 32'd1, 1'b0);
        res32("sub 0-1", 32'hFFFF_FFFF, 4'b1000);
        issue32(4'd7, 32'h8000_0000, 32'd1, 1'b0);
        res32("sub ovf", 32'h7FFF_FFFF, 4'b0011);
        issue32(4'd7, 32'd10, 32'd3, 1'b1);
        res32("sub cin ignored", 32'd7, 4'b0001);
        issue32(4'd6, 32'h8000_0000, 32'd31, 1'b0);
        res32("srl 31", 32'h1, 4'b0000);
        issue32(4'd5, 32'd1, 32'h120, 1'b0);
        res32("sll upper B ignored", 32'h1, 4'b0000);
        issue32(4'd4, 32'd0, 32'd0, 1'b1);
        res32("nor", 32'hFFFF_FFFF, 4'b1000);
        issue32(4'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);
        res32("xor", 32'hF0F0_0F0F, 4'b1000);
        issue32(4'd9, 32'd1, 32'd2, 1'b1);
        res32("op9 as add", 32'd4, 4'b0000);

        mul32("mul 2^16*2^16", 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0101);
        mul32("mul 6*7", 32'd6, 32'd7, 32'd42, 4'b0000);

        @(posedge clk); #1;
        check("idle after drain", 32'(ov32), 32'd0);
        or32 = 1'b0;
        issue32(4'd2, 32'h1234_0000, 32'h0000_5678, 1'b0);
        res32("or", 32'h1234_5678, 4'b0000);
        iv32 = 1'b1; sel32 = 4'd1; a32 = 32'hF0F0_F0F0; b32 = 32'hFF00_FF00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            res32("stall hold", 32'h1234_5678, 4'b0000);
            check("stall in_ready", 32'(ir32), 32'd0);
        end
        or32 = 1'b1;
        #1;
        check("release in_ready", 32'(ir32), 32'd1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        res32("back-to-back and", 32'hF000_F000, 4'b1000);
        @(posedge clk); #1;
        check("drain out_valid", 32'(ov32), 32'd0);

        issue32(4'd8, 32'd3, 32'd5, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort out_valid", 32'(ov32), 32'd0);
        check("abort Output", o32, 32'd0);
        check("abort nzvc", 32'({n32, z32, v32, c32}), 32'd0);
        check("abort in_ready", 32'(ir32), 32'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ov32 || o32 != 32'd0) stale++;
        end
        check("no stale mul result", 32'(stale), 32'd0);

        iv8 = 1'b1; sel8 = 4'd0; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        check("w8 add valid", 32'(ov8), 32'd1);
        check("w8 add out", 32'(o8), 32'h80);
        check("w8 add nzvc", 32'({n8, z8, v8, c8}), 32'b1010);

        iv8 = 1'b1; sel8 = 4'd8; a8 = 8'd16; b8 = 8'd16;
        @(posedge clk); #1;
        iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("w8 mul latency", 32'(cyc), 32'd8);
        check("w8 mul out", 32'(o8), 32'h0);
        check("w8 mul nzvc", 32'({n8, z8, v8, c8}), 32'b0101);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
